// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: FSM state encoding and
// default timing constants.
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 16;
    localparam int DEFAULT_SYNC_STAGES   = 2;

    // Two stable levels, each with a qualifying state that counts the
    // opposite level before the debounced output is allowed to change.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer bringing the asynchronous switch input into the
// clk domain. Only the last stage is used by downstream logic.
module sync_ff
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stage_d;
    logic [SYNC_STAGES-1:0] stage_q;

    // Shift the raw input one stage deeper each clock.
    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d};
    end

    // Synchronizer flops, cleared immediately by reset.
    // NOTE: registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Debouncer for a bouncing mechanical switch. The synchronized input must
// hold a new level for STABLE_CYCLES consecutive samples before the
// registered level w follows it; any shorter run is discarded entirely.
module input_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic w,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int             CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync_in;

    db_state_e        state_d, state_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             w_d,     w_q;
    logic             rise_d,  rise_q;
    logic             fall_d,  fall_q;

    sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (raw_in),
        .q    (sync_in)
    );

    // Next-state logic: count consecutive opposite-level samples, abandon the
    // run on the first disagreeing sample, flip w when the run completes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            STABLE_LOW: begin
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    w_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    w_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                w_d     = 1'b0;
            end
        endcase
    end

    // FSM state, run counter and registered outputs; reset forces a clean
    // low level with no strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign w          = w_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer (STABLE_CYCLES=4, SYNC_STAGES=2).
// Stimulus drives raw_in at each falling edge and queues the expected
// outputs for the next rising edge; a monitor pops and compares them.
module tb_input_debouncer;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    typedef struct {
        int   idx;
        logic w;
        logic rise;
        logic fall;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_in = 1'b0;
    logic w, rise_pulse, fall_pulse;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];

    // Reference model: raw samples per edge, the level the decision logic sees
    // per edge, and the debounced level.
    logic samples[$];
    logic seen[$];
    logic m_w = 1'b0;
    logic prev_reset = 1'b0;
    int   edge_idx = 0;

    int last_rise_edge = -1;
    int last_fall_edge = -1;
    int rise_count = 0;
    int fall_count = 0;

    input_debouncer #(
        .STABLE_CYCLES(STABLE),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .w         (w),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive inputs at the falling edge and queue what
    // the outputs must be after the following rising edge.
    task automatic step(input logic v, input logic rst_v = 1'b0);
        exp_t x;
        bit   flip;
        logic s;
        @(negedge clk);
        reset  = rst_v;
        raw_in = v;
        edge_idx++;
        x.idx  = edge_idx;
        x.rise = 1'b0;
        x.fall = 1'b0;
        if (rst_v) begin
            samples.delete();
            seen.delete();
            m_w = 1'b0;
            x.w = 1'b0;
        end else begin
            samples.push_back(v);
            s = (samples.size() > SYNC) ? samples[samples.size()-1-SYNC] : 1'b0;
            seen.push_back(s);
            if (samples.size() > SYNC + 1) void'(samples.pop_front());
            if (seen.size() > STABLE) void'(seen.pop_front());
            flip = (seen.size() == STABLE);
            foreach (seen[i]) if (seen[i] == m_w) flip = 1'b0;
            if (flip) begin
                m_w = ~m_w;
                x.rise = m_w;
                x.fall = ~m_w;
            end
            x.w = m_w;
        end
        sb.push_back(x);
        if (rst_v && !prev_reset) begin
            #1;
            check("reset_w", w, 0);
            check("reset_rise", rise_pulse, 0);
            check("reset_fall", fall_pulse, 0);
        end
        prev_reset = rst_v;
    endtask

    task automatic run(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic wait_mon();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare every rising edge's outputs against the queued entry.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                check($sformatf("w@%0d", x.idx), w, x.w);
                check($sformatf("rise@%0d", x.idx), rise_pulse, x.rise);
                check($sformatf("fall@%0d", x.idx), fall_pulse, x.fall);
                if (rise_pulse && fall_pulse) check("both_pulses", 1, 0);
                if (rise_pulse) begin last_rise_edge = x.idx; rise_count++; end
                if (fall_pulse) begin last_fall_edge = x.idx; fall_count++; end
            end
        end
    end

    initial begin
        int e0, rc, fc;
        logic lvl;

        // Reset state.
        step(0, 1); step(0, 1);
        run(0, 3);

        // Clean press: w rises on the 6th edge after the change.
        e0 = edge_idx + 1;
        run(1, 8);
        wait_mon();
        check("clean_rise_edge", last_rise_edge, e0 + 5);

        // Back low, then a bounce before the final press.
        run(0, 8);
        step(0, 1); step(0, 1);
        run(0, 3);
        rc = rise_count;
        run(1, 3);
        step(0);
        e0 = edge_idx + 1;
        run(1, 8);
        wait_mon();
        check("bounce_rise_edge", last_rise_edge, e0 + 5);
        check("bounce_rise_count", rise_count - rc, 1);

        // Short low glitch while w is high.
        fc = fall_count;
        run(0, 2);
        run(1, 8);
        wait_mon();
        check("glitch_no_fall", fall_count - fc, 0);
        check("glitch_w_high", w, 1);

        // Release: w falls on the 6th edge; full press/release shows 0,1,0.
        e0 = edge_idx + 1;
        run(0, 8);
        wait_mon();
        check("release_fall_edge", last_fall_edge, e0 + 5);
        check("press_release_rises", rise_count - rc, 1);
        check("press_release_falls", fall_count - fc, 1);

        // Reset mid-count with raw_in held high through release.
        rc = rise_count;
        run(1, 3);
        step(1, 1); step(1, 1);
        check("midcount_no_rise", rise_count - rc, 0);
        e0 = edge_idx + 1;
        run(1, 8);
        wait_mon();
        check("post_reset_rise_edge", last_rise_edge, e0 + 5);
        check("post_reset_rise_count", rise_count - rc, 1);

        // Random bursts of bouncing, steady levels and occasional resets.
        lvl = 1'b1;
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(lvl, 1);
            end else begin
                if ($urandom_range(0, 1) == 1) lvl = ~lvl;
                run(lvl, $urandom_range(1, 10));
            end
        end
        run(lvl, 10);

        wait_mon();
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: the stimulus is bounded, but never let the run hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
